alu_ip: RTL and testbench
=========================

// Module: alu_ip
// PURPOSE
//  Registered 8-bit signed ALU for the datapath. One of eight operations on A and B is selected by sel.
//  The result is registered to C together with a zero flag Z.
//  Single-cycle throughput with one-cycle latency; it is driven directly by data-file stimulus benches.
// PARAMETERS
//  W     8   operand/result width (two's complement); all behaviour below stated for W=8
// PORTS
//  clk   in   1   clock, all state updates on rising edge
//  rst   in   1   reset, synchronous, active-high
//  sel   in   3   operation select (alu_pkg::alu_op_e)
//  A     in   8   signed operand A
//  B     in   8   signed operand B
//  C     out  8   signed registered result
//  Z     out  1   registered zero flag: 1 when C == 0
// BEHAVIOUR
//  - Clocking: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset: on the posedge where rst=1, C <= 8'sd0 and Z <= 1'b1; rst has priority over any operation.
//  - Latency: inputs sampled at posedge N appear on C/Z after posedge N; new op accepted every cycle, no handshake.
//  - No input registering: A, B and sel feed combinational logic that drives the C/Z registers.
//  - Operation table (sel):
//    000 ADD   C = A + B, truncated to 8 bits (wraps; 127+1 = -128)
//    001 SUB   C = A - B, truncated to 8 bits (wraps; -128-1 = 127)
//    010 AND   C = A & B
//    011 OR    C = A | B
//    100 XOR   C = A ^ B
//    101 SLL   C = A << B[2:0], zero-fill; B[7:3] ignored
//    110 SRA   C = A >>> B[2:0], sign-fill; B[7:3] ignored
//    111 SLT   C = (A < B, signed compare) ? 1 : 0
//  - No overflow/carry outputs; arithmetic overflow wraps silently.
//  - Z is computed from the next-C value and registered in the same cycle, so Z always matches C.
//  - X/undefined sel is not legal; the default branch of the case yields C = 0.
//  - Reset asserted mid-stream discards the in-flight op. The first op after rst deasserts is visible one cycle later.
// STRUCTURE
//  - Package alu_pkg holds:
//    - localparam W = 8
//    - typedef enum logic [2:0] alu_op_e {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRA, ALU_SLT}
//    - typedef logic signed [W-1:0] word_t
//  - Sub-module alu_core: purely combinational (sel, A, B -> result, zero).
//  - alu_ip wraps alu_core and adds the C/Z registers and reset.
// TESTING
//  - Reset: rst=1 for 2 cycles with A=5, B=3, sel=ADD -> C=0, Z=1; C=8 one cycle after rst drops.
//  - Arithmetic wrap: A=127, B=1, sel=000 -> C=-128, Z=0; A=-128, B=1, sel=001 -> C=127.
//  - Logic: A=8'h0F, B=8'h3C, sel=010/011/100 on consecutive cycles -> C=8'h0C, 8'h3F, 8'h33 on the following cycles.
//  - Shifts: A=-16, B=2, sel=110 -> C=-4; A=3, B=8'h0A, sel=101 -> C=12 (only B[2:0]=2 used).
//  - Compare/zero: A=-5, B=3, sel=111 -> C=1, Z=0; A=7, B=7, sel=001 -> C=0, Z=1.
//  - Streaming: new random A/B/sel every cycle for 1000 cycles -> C/Z match the golden model delayed by exactly 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared width, operation encoding and word type for the registered ALU.
package alu_pkg;

   localparam int W = 8;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRA = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   typedef logic signed [W-1:0] word_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: selects one of eight operations and flags a zero result.
module alu_core
   import alu_pkg::*;
(
   input  logic [2:0]   sel_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] result_o,
   output logic         zero_o
);

   word_t aS;
   word_t bS;
   word_t resultS;

   assign aS = word_t'(a_i);
   assign bS = word_t'(b_i);

   // Shifts use only the low three bits of B so the amount never exceeds the word width.
   always_comb begin
      resultS = '0;
      case (alu_op_e'(sel_i))
         ALU_ADD: resultS = aS + bS;
         ALU_SUB: resultS = aS - bS;
         ALU_AND: resultS = aS & bS;
         ALU_OR:  resultS = aS | bS;
         ALU_XOR: resultS = aS ^ bS;
         ALU_SLL: resultS = aS << bS[2:0];
         ALU_SRA: resultS = aS >>> bS[2:0];
         ALU_SLT: resultS = (aS < bS) ? word_t'(1) : word_t'(0);
         default: resultS = '0;
      endcase
   end

   assign result_o = resultS;
   assign zero_o   = (resultS == '0);

endmodule

// File: rtl/alu_ip.sv
// Registered ALU: wraps alu_core and holds the result and zero flag for one cycle of latency.
module alu_ip
   import alu_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   sel,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] C,
   output logic         Z
);

   logic [W-1:0] cD;
   logic [W-1:0] cQ;
   logic         zD;
   logic         zQ;

   alu_core uCore (
      .sel_i    (sel),
      .a_i      (A),
      .b_i      (B),
      .result_o (cD),
      .zero_o   (zD)
   );

   // Z is registered alongside C from the same next value so the two never disagree.
   always_ff @(posedge clk) begin
      if (rst) begin
         cQ <= '0;
         zQ <= 1'b1;
      end else begin
         cQ <= cD;
         zQ <= zD;
      end
   end

   assign C = cQ;
   assign Z = zQ;

endmodule

// File: tb/tb_alu_ip.sv
// Directed vector table, hand-written reset sequences and a random stream against an integer model.
module tb_alu_ip;

   typedef struct {
      logic       rst;
      logic [2:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] expC;
      logic       expZ;
      string      name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] sel;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] C;
   logic       Z;

   int vecCount  = 0;
   int missCount = 0;
   vec_t vecs[$];

   alu_ip dut (
      .clk (clk),
      .rst (rst),
      .sel (sel),
      .A   (A),
      .B   (B),
      .C   (C),
      .Z   (Z)
   );

   always #5 clk = ~clk;

   // Reference built on integer arithmetic rather than the RTL's word operators.
   function automatic logic [7:0] modelC(logic [2:0] s, logic [7:0] a, logic [7:0] b);
      int ia  = int'($signed(a));
      int ib  = int'($signed(b));
      int sh  = int'(b[2:0]);
      int pw  = 1 << sh;
      int r   = 0;
      case (s)
         3'd0: r = ia + ib;
         3'd1: r = ia - ib;
         3'd2: r = int'(a & b);
         3'd3: r = int'(a | b);
         3'd4: r = int'(a ^ b);
         3'd5: r = ia * pw;
         3'd6: begin
            r = ia / pw;
            if (ia < 0 && (ia % pw) != 0) r = r - 1;
         end
         default: r = (ia < ib) ? 1 : 0;
      endcase
      return r[7:0];
   endfunction

   task automatic addVec(input logic r, input logic [2:0] s, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c, input logic z,
                         input string n);
      vec_t v;
      v.rst = r; v.sel = s; v.a = a; v.b = b; v.expC = c; v.expZ = z; v.name = n;
      vecs.push_back(v);
   endtask

   // Drives one cycle of inputs and waits until the resulting registered output is stable.
   task automatic applyStimulus(input logic r, input logic [2:0] s, input logic [7:0] a,
                                input logic [7:0] b);
      rst = r; sel = s; A = a; B = b;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string n, input logic [7:0] expC, input logic expZ);
      vecCount++;
      if (C !== expC || Z !== expZ) begin
         missCount++;
         $display("[TB] FAIL %s: got C=%0d Z=%b, expected C=%0d Z=%b",
                  n, $signed(C), Z, $signed(expC), expZ);
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [2:0] rs;
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] ec;

      rst = 1'b1; sel = 3'd0; A = '0; B = '0;

      addVec(0, 3'b000, 8'd127,  8'd1,   8'h80, 1'b0, "add_wrap");
      addVec(0, 3'b001, 8'h80,   8'd1,   8'd127, 1'b0, "sub_wrap");
      addVec(0, 3'b110, 8'hF0,   8'd2,   8'hFC, 1'b0, "sra_neg");
      addVec(0, 3'b101, 8'd3,    8'h0A,  8'd12, 1'b0, "sll_bhigh_ignored");
      addVec(0, 3'b111, 8'hFB,   8'd3,   8'd1,  1'b0, "slt_true");
      addVec(0, 3'b001, 8'd7,    8'd7,   8'd0,  1'b1, "sub_zero");
      addVec(0, 3'b111, 8'd3,    8'hFB,  8'd0,  1'b1, "slt_false");
      addVec(0, 3'b111, 8'd7,    8'd7,   8'd0,  1'b1, "slt_equal");
      addVec(0, 3'b110, 8'hFF,   8'd7,   8'hFF, 1'b0, "sra_minus1");
      addVec(0, 3'b110, 8'h40,   8'h0F,  8'h00, 1'b1, "sra_pos_max");
      addVec(0, 3'b101, 8'h81,   8'hFF,  8'h80, 1'b0, "sll_max");
      addVec(0, 3'b000, 8'hFF,   8'd1,   8'd0,  1'b1, "add_to_zero");
      addVec(0, 3'b100, 8'h55,   8'h55,  8'd0,  1'b1, "xor_zero");
      addVec(0, 3'b001, 8'd0,    8'h80,  8'h80, 1'b0, "sub_neg_min");

      // Reset held for two cycles with a live ADD on the inputs.
      applyStimulus(1, 3'b000, 8'd5, 8'd3);
      checkOutput("reset_c1", 8'd0, 1'b1);
      applyStimulus(1, 3'b000, 8'd5, 8'd3);
      checkOutput("reset_c2", 8'd0, 1'b1);
      applyStimulus(0, 3'b000, 8'd5, 8'd3);
      checkOutput("first_after_reset", 8'd8, 1'b0);

      // Logic ops on consecutive cycles.
      applyStimulus(0, 3'b010, 8'h0F, 8'h3C);
      checkOutput("and", 8'h0C, 1'b0);
      applyStimulus(0, 3'b011, 8'h0F, 8'h3C);
      checkOutput("or", 8'h3F, 1'b0);
      applyStimulus(0, 3'b100, 8'h0F, 8'h3C);
      checkOutput("xor", 8'h33, 1'b0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].sel, vecs[i].a, vecs[i].b);
         checkOutput(vecs[i].name, vecs[i].expC, vecs[i].expZ);
      end

      // Reset mid-stream discards the in-flight op.
      applyStimulus(0, 3'b000, 8'd100, 8'd20);
      checkOutput("pre_midreset", 8'd120, 1'b0);
      applyStimulus(1, 3'b000, 8'd100, 8'd20);
      checkOutput("midreset", 8'd0, 1'b1);
      applyStimulus(0, 3'b000, 8'd1, 8'd1);
      checkOutput("post_midreset", 8'd2, 1'b0);

      for (int n = 0; n < 1000; n++) begin
         rs = 3'($urandom_range(7, 0));
         ra = 8'($urandom);
         rb = 8'($urandom);
         ec = modelC(rs, ra, rb);
         applyStimulus(0, rs, ra, rb);
         checkOutput($sformatf("stream_%0d_op%0d", n, rs), ec, ec == 8'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
